// File: rtl/i2c_codec_pkg.sv
// Shared types and constants for the I2C codec register-write responder.
package i2c_codec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEV,
        ACK_DEV,
        REG,
        ACK_REG,
        DATA,
        ACK_DATA,
        IGNORE
    } state_t;

    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h1A;
    localparam logic [6:0] CODEC_RESET_IDX  = 7'h0F;
    localparam int         REG_COUNT        = 16;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for the I2C lines plus SCL edge and START/STOP detection.
module i2c_bus_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic scl_meta;
    logic sda_meta;
    logic scl;
    logic scl_prev;
    logic sda_prev;

    // Flops reset to the idle-bus level so leaving reset never looks like an edge on a quiet bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_meta <= 1'b1;
            scl      <= 1'b1;
            scl_prev <= 1'b1;
            sda_meta <= 1'b1;
            sda      <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_meta <= scl_in;
            scl      <= scl_meta;
            scl_prev <= scl;
            sda_meta <= sda_in;
            sda      <= sda_meta;
            sda_prev <= sda;
        end
    end

    assign scl_rise  = scl & ~scl_prev;
    assign scl_fall  = ~scl & scl_prev;
    assign start_det = scl & scl_prev & sda_prev & ~sda;
    assign stop_det  = scl & scl_prev & ~sda_prev & sda;

endmodule

// File: rtl/i2c_codec_responder.sv
// I2C write-only responder: accepts {addr,W}, {index,d8}, {d7..d0} and commits
// the 9-bit value into a 16-entry register file.
module i2c_codec_responder
    import i2c_codec_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic       reg_wr,
    output logic [6:0] reg_addr,
    output logic [8:0] reg_data,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       busy
);

    state_t      state;
    state_t      state_next;
    logic        sda_s;
    logic        scl_rise;
    logic        scl_fall;
    logic        start_det;
    logic        stop_det;
    logic        start_ok;
    logic        stop_ok;
    logic        in_byte;
    logic        byte_done;
    logic        sda_low;
    logic        commit;
    logic [7:0]  shift_reg;
    logic [3:0]  bit_cnt;
    logic [7:0]  reg_byte;
    logic [8:0]  reg_file [REG_COUNT];

    i2c_bus_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (I2C_SCLK),
        .sda_in    (I2C_SDAT),
        .sda       (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    // A START and STOP in the same clk can only be a glitch, so both are dropped.
    assign start_ok  = start_det & ~stop_det;
    assign stop_ok   = stop_det & ~start_det;
    assign byte_done = in_byte & scl_fall & (bit_cnt == 4'd8);

    assign I2C_SDAT = sda_low ? 1'b0 : 1'bz;
    assign rd_data  = reg_file[rd_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (start_ok) begin
            state_next = DEV;
        end else if (stop_ok) begin
            state_next = IDLE;
        end else begin
            case (state)
                DEV:      if (byte_done) state_next = (shift_reg == {DEV_ADDR, 1'b0}) ? ACK_DEV : IGNORE;
                ACK_DEV:  if (scl_fall)  state_next = REG;
                REG:      if (byte_done) state_next = ACK_REG;
                ACK_REG:  if (scl_fall)  state_next = DATA;
                DATA:     if (byte_done) state_next = ACK_DATA;
                ACK_DATA: if (scl_fall)  state_next = IGNORE;
                default:  state_next = state;
            endcase
        end
    end

    // The ACK drive follows the state, so it only ever changes on a synchronized SCL fall.
    always_comb begin
        sda_low = 1'b0;
        commit  = 1'b0;
        in_byte = 1'b0;
        busy    = (state != IDLE);
        case (state)
            DEV, REG, DATA:   in_byte = 1'b1;
            ACK_DEV, ACK_REG: sda_low = 1'b1;
            ACK_DATA: begin
                sda_low = 1'b1;
                commit  = scl_fall;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            reg_byte  <= '0;
            reg_wr    <= 1'b0;
            reg_addr  <= '0;
            reg_data  <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                reg_file[i] <= '0;
            end
        end else begin
            reg_wr <= commit;
            if (start_ok || stop_ok) begin
                bit_cnt <= '0;
            end else if (in_byte && scl_rise && bit_cnt != 4'd8) begin
                shift_reg <= {shift_reg[6:0], sda_s};
                bit_cnt   <= bit_cnt + 4'd1;
            end else if (byte_done) begin
                bit_cnt <= '0;
                if (state == REG) begin
                    reg_byte <= shift_reg;
                end
            end

            // The data byte is still in shift_reg because ACK states never shift.
            if (commit) begin
                reg_addr <= reg_byte[7:1];
                reg_data <= {reg_byte[0], shift_reg};
                if (reg_byte[7:1] == CODEC_RESET_IDX) begin
                    for (int i = 0; i < REG_COUNT; i++) begin
                        reg_file[i] <= '0;
                    end
                end else if (reg_byte[7:5] == 3'b000) begin
                    reg_file[reg_byte[4:1]] <= {reg_byte[0], shift_reg};
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Bench for i2c_codec_responder: a bit-banged I2C master with a transaction-level
// model of acks, commits and register-file contents.
module tb_i2c_codec_responder;
    import i2c_codec_pkg::*;

    localparam int         Q     = 8;
    localparam logic [7:0] DEV_W = {DEFAULT_DEV_ADDR, 1'b0};

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       master_low;
    wire        sda_bus;
    logic       reg_wr;
    logic [6:0] reg_addr;
    logic [8:0] reg_data;
    logic [3:0] rd_addr;
    logic [8:0] rd_data;
    logic       busy;

    int         errors = 0;
    int         checks = 0;
    int         wr_count = 0;
    int         exp_wr_count = 0;
    logic [8:0] exp_regs [16];
    logic [6:0] exp_reg_addr;
    logic [8:0] exp_reg_data;
    bit         check_en = 1'b0;
    bit         commit_window = 1'b0;
    bit         ack_window = 1'b0;
    bit         rd_random = 1'b1;
    bit         tx_aborted = 1'b0;
    logic       reg_wr_prev;
    logic [7:0] tx_q [$];
    logic [7:0] tx_b1;
    logic [7:0] tx_b2;

    assign sda_bus = master_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_codec_responder #(.DEV_ADDR(DEFAULT_DEV_ADDR)) dut (
        .clk      (clk),
        .reset    (reset),
        .I2C_SCLK (scl),
        .I2C_SDAT (sda_bus),
        .reg_wr   (reg_wr),
        .reg_addr (reg_addr),
        .reg_data (reg_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rd_random) rd_addr = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic model_reset();
        foreach (exp_regs[i]) exp_regs[i] = '0;
        exp_reg_addr = '0;
        exp_reg_data = '0;
    endtask

    // Register-write rule: index 0x0F clears the file, indices above 0x0F store nothing.
    task automatic model_write();
        logic [6:0] idx;
        logic [8:0] data;
        idx  = tx_b1[7:1];
        data = {tx_b1[0], tx_b2};
        exp_reg_addr = idx;
        exp_reg_data = data;
        exp_wr_count++;
        if (idx == 7'h0F) begin
            foreach (exp_regs[i]) exp_regs[i] = '0;
        end else if (idx < 7'h10) begin
            exp_regs[idx[3:0]] = data;
        end
    endtask

    task automatic bus_start();
        master_low = 1'b0;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(Q);
        master_low = 1'b1;
        wait_clks(Q);
        scl = 1'b0;
        wait_clks(Q);
        check_output("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic bus_stop();
        master_low = 1'b1;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(Q);
        master_low = 1'b0;
        wait_clks(2 * Q);
        check_output("busy_after_stop", 32'(busy), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit exp_ack, input bit do_commit, input int reset_bit);
        bit got_ack;
        for (int i = 7; i >= 0; i--) begin
            master_low = ~b[i];
            if ((7 - i) == reset_bit) begin
                check_en = 1'b0;
                reset = 1'b1;
                wait_clks(3);
                reset = 1'b0;
                model_reset();
                check_en = 1'b1;
                tx_aborted = 1'b1;
                exp_ack = 1'b0;
                do_commit = 1'b0;
            end
            wait_clks(Q);
            scl = 1'b1;
            wait_clks(2 * Q);
            scl = 1'b0;
            if (i == 0) ack_window = exp_ack;
            wait_clks(Q);
        end
        master_low = 1'b0;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(Q);
        got_ack = (sda_bus === 1'b0);
        wait_clks(Q);
        scl = 1'b0;
        if (do_commit) begin
            commit_window = 1'b1;
            check_en = 1'b0;
        end
        wait_clks(6);
        ack_window = 1'b0;
        if (do_commit) begin
            model_write();
            commit_window = 1'b0;
            check_en = 1'b1;
        end
        wait_clks(Q - 6);
        check_output("ack", 32'(got_ack), 32'(exp_ack));
    endtask

    task automatic run_transaction(input int reset_byte, input int reset_bit, input bit with_stop);
        bit addressed;
        bit exp_ack;
        bit do_commit;
        tx_aborted = 1'b0;
        if (tx_q.size() > 1) tx_b1 = tx_q[1];
        if (tx_q.size() > 2) tx_b2 = tx_q[2];
        bus_start();
        addressed = (tx_q[0] == DEV_W);
        for (int k = 0; k < tx_q.size(); k++) begin
            exp_ack   = addressed && (k < 3) && !tx_aborted;
            do_commit = addressed && (k == 2) && !tx_aborted;
            send_byte(tx_q[k], exp_ack, do_commit, (k == reset_byte) ? reset_bit : -1);
        end
        check_output("busy_mid", 32'(busy), 32'(!tx_aborted));
        if (with_stop) bus_stop();
        check_output("wr_count", 32'(wr_count), 32'(exp_wr_count));
    endtask

    task automatic set_bytes(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        tx_q.delete();
        tx_q.push_back(b0);
        if (n > 1) tx_q.push_back(b1);
        if (n > 2) tx_q.push_back(b2);
    endtask

    task automatic check_rd(input string name, input logic [3:0] a, input logic [8:0] expected);
        rd_random = 1'b0;
        rd_addr = a;
        wait_clks(1);
        check_output(name, 32'(rd_data), 32'(expected));
        rd_random = 1'b1;
    endtask

    task automatic apply_stimulus(input int n_tx);
        int         n;
        bit         with_stop;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         r;
        for (int t = 0; t < n_tx; t++) begin
            n  = $urandom_range(1, 5);
            b0 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : DEV_W;
            r  = $urandom_range(0, 9);
            if (r == 0)     b1 = {7'h0F, 1'($urandom_range(0, 1))};
            else if (r < 3) b1 = {7'($urandom_range(16, 127)), 1'($urandom_range(0, 1))};
            else            b1 = {3'b000, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1))};
            b2 = 8'($urandom_range(0, 255));
            tx_q.delete();
            tx_q.push_back(b0);
            if (n > 1) tx_q.push_back(b1);
            if (n > 2) tx_q.push_back(b2);
            for (int k = 3; k < n; k++) tx_q.push_back(8'($urandom_range(0, 255)));
            with_stop = ($urandom_range(0, 4) != 0) || (t == n_tx - 1);
            run_transaction(-1, -1, with_stop);
        end
    endtask

    // Per-cycle comparison of every observable output against the model.
    initial begin
        reg_wr_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                reg_wr_prev = 1'b0;
            end else begin
                if (!ack_window) check_output("sda_release", 32'((sda_bus === 1'b0) && !master_low), 32'd0);
                if (!commit_window) check_output("reg_wr_spurious", 32'(reg_wr), 32'd0);
                if (reg_wr) begin
                    wr_count++;
                    check_output("reg_wr_width", 32'(reg_wr_prev), 32'd0);
                end
                if (check_en) begin
                    check_output("rd_data", 32'(rd_data), 32'(exp_regs[rd_addr]));
                    check_output("reg_addr", 32'(reg_addr), 32'(exp_reg_addr));
                    check_output("reg_data", 32'(reg_data), 32'(exp_reg_data));
                end
                reg_wr_prev = reg_wr;
            end
        end
    end

    initial begin
        #10000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        int wr_before;
        reset = 1'b1;
        scl = 1'b1;
        master_low = 1'b0;
        rd_addr = '0;
        model_reset();
        wait_clks(5);
        check_output("reset_reg_wr", 32'(reg_wr), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        wait_clks(3);
        check_en = 1'b1;
        check_output("reset_reg_addr", 32'(reg_addr), 32'd0);
        check_output("reset_reg_data", 32'(reg_data), 32'd0);
        for (int a = 0; a < 16; a++) check_rd("reset_rd", 4'(a), 9'h000);

        $display("[TB] basic write to index 2");
        set_bytes(3, 8'h34, 8'h04, 8'h79);
        run_transaction(-1, -1, 1'b1);
        check_output("lit_reg_addr", 32'(reg_addr), 32'h02);
        check_output("lit_reg_data", 32'(reg_data), 32'h079);
        check_output("lit_wr_one", 32'(wr_count), 32'd1);
        check_rd("lit_rd2", 4'd2, 9'h079);

        $display("[TB] write then codec reset");
        set_bytes(3, 8'h34, 8'h05, 8'h16);
        run_transaction(-1, -1, 1'b1);
        check_rd("lit_rd2_116", 4'd2, 9'h116);
        set_bytes(3, 8'h34, 8'h1E, 8'h00);
        run_transaction(-1, -1, 1'b1);
        check_rd("lit_rd2_cleared", 4'd2, 9'h000);
        check_output("lit_reg_addr_0f", 32'(reg_addr), 32'h0F);

        $display("[TB] foreign address and read bit");
        wr_before = wr_count;
        set_bytes(3, 8'h36, 8'h04, 8'h79);
        run_transaction(-1, -1, 1'b1);
        set_bytes(3, 8'h35, 8'h04, 8'h79);
        run_transaction(-1, -1, 1'b1);
        check_output("lit_ignore_no_wr", 32'(wr_count), 32'(wr_before));

        $display("[TB] stop before data byte");
        set_bytes(2, 8'h34, 8'h06, 8'h00);
        run_transaction(-1, -1, 1'b1);
        check_output("lit_early_stop_no_wr", 32'(wr_count), 32'(wr_before));

        $display("[TB] repeated start");
        set_bytes(2, 8'h34, 8'h08, 8'h00);
        run_transaction(-1, -1, 1'b0);
        set_bytes(3, 8'h34, 8'h10, 8'h02);
        run_transaction(-1, -1, 1'b1);
        check_output("lit_rs_reg_addr", 32'(reg_addr), 32'h08);
        check_output("lit_rs_reg_data", 32'(reg_data), 32'h002);
        check_output("lit_rs_wr", 32'(wr_count), 32'(wr_before + 1));
        check_rd("lit_rd8", 4'd8, 9'h002);

        $display("[TB] reset during data byte");
        wr_before = wr_count;
        set_bytes(3, 8'h34, 8'h0A, 8'hAB);
        run_transaction(2, 4, 1'b1);
        check_output("lit_abort_no_wr", 32'(wr_count), 32'(wr_before));
        check_rd("lit_rd8_cleared", 4'd8, 9'h000);
        set_bytes(3, 8'h34, 8'h0C, 8'h5A);
        run_transaction(-1, -1, 1'b1);
        check_rd("lit_rd6", 4'd6, 9'h05A);

        $display("[TB] randomized transactions");
        apply_stimulus(20);

        wait_clks(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_codec_responder.md
I2C_CODEC_RESPONDER -- requirements
Module: i2c_codec_responder

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h1A, the 7-bit I2C device address it answers to.
REQ-002 SHALL have port clk  input  1  system clock, at least 20x the I2C_SCLK rate; all logic runs on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port I2C_SCLK  input  1  I2C clock from the bus master.
REQ-005 SHALL have port I2C_SDAT  inout  1  I2C data; open-drain, driven only to 0 or high-Z.
REQ-006 SHALL have port reg_wr  output  1  one-clk pulse when a register write commits.
REQ-007 SHALL have port reg_addr  output  7  register index of the last committed write.
REQ-008 SHALL have port reg_data  output  9  data of the last committed write.
REQ-009 SHALL have port rd_addr  input  4  read-port index into the register file.
REQ-010 SHALL have port rd_data  output  9  combinational register-file content at rd_addr.
REQ-011 SHALL have port busy  output  1  high from a detected START until the next STOP.

Function
REQ-012 SHALL synchronize I2C_SCLK and I2C_SDAT through 2 flops each, and derive all edges from the synchronized values.
REQ-013 SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-014 SHALL sample data bits on SCL rising edges, MSB first, and change its SDA drive only on SCL falling edges.
REQ-015 SHALL implement the FSM states IDLE, DEV, ACK_DEV, REG, ACK_REG, DATA, ACK_DATA and IGNORE.
REQ-016 SHALL receive byte 1 in DEV and go to ACK_DEV when it is {DEV_ADDR,0}; any other value, including the read bit set, SHALL send the FSM to IGNORE with no ACK.
REQ-017 SHALL drive SDA low in each ACK_* state, from the SCL falling edge after bit 8 until the SCL falling edge after bit 9.
REQ-018 SHALL treat byte 2 as follows: bits[7:1] are the register index and bit[0] is data bit 8.
REQ-019 SHALL take byte 3 as data bits [7:0].
REQ-020 SHALL commit the write after ACK_DATA ends, then go to IGNORE, NACKing any further bytes.
REQ-021 SHALL, on commit, update reg_addr and reg_data, pulse reg_wr for exactly 1 clk, and write the 16x9 register file at index[3:0].
REQ-022 SHALL write nothing to the register file when the index is above 4'hF in 7-bit space (index >= 7'h10), although reg_wr still pulses.
REQ-023 SHALL, when a write commits to index 7'h0F (codec reset), clear all 16 register-file entries to 0 in the same clk, instead of storing the data.
REQ-024 SHALL go to DEV on a repeated START from any state, discarding any partial bytes.
REQ-025 SHALL go to IDLE on a STOP in any state; a STOP before commit SHALL produce no write.
REQ-026 SHALL ignore a START and a STOP seen in the same clk (glitch), leaving the state unchanged.
REQ-027 SHALL assert reg_wr 1 clk after the synchronized SCL falling edge that ends ACK_DATA.

Reset
REQ-028 SHALL, while reset is high, set the FSM to IDLE, SDA to high-Z, reg_wr, busy, reg_addr and reg_data to 0, and all register-file entries to 0.
REQ-029 SHALL abandon a transaction when reset is asserted mid-transaction, with no commit and no ACK held; after reset it SHALL wait for a new START.

Structure
REQ-030 SHALL take the FSM state enum, the default DEV_ADDR value 7'h1A and the codec-reset index 7'h0F from a shared package, i2c_codec_pkg.
REQ-031 SHALL place the synchronizer and START/STOP/edge detection in one sub-module, i2c_bus_sync.

Verification
REQ-032 SHALL cover this scenario: write 0x34, 0x04, 0x79 -> ACK on all three bytes, one reg_wr pulse with reg_addr=7'h02 and reg_data=9'h079, and rd_data at rd_addr 2 reads 9'h079.
REQ-033 SHALL cover this scenario: write 0x34, 0x05, 0x16, then write 0x34, 0x1E, 0x00 -> after the second write, rd_data at rd_addr 2 reads 9'h000.
REQ-034 SHALL cover this scenario: byte 0x36, or byte 0x35 -> SDA never driven low, FSM in IGNORE, no reg_wr until STOP.
REQ-035 SHALL cover this scenario: 0x34, 0x06, then STOP -> two ACKs, no reg_wr, busy falls after STOP.
REQ-036 SHALL cover this scenario: 0x34, 0x08, repeated START, 0x34, 0x10, 0x02 -> one reg_wr with reg_addr=7'h08 and reg_data=9'h002.
REQ-037 SHALL cover this scenario: reset pulsed during bit 5 of byte 3 -> SDA high-Z, no reg_wr, and the next full transaction is accepted normally.
